// File: rtl/rr_arb8_ctrl_if.sv
// rtl/rr_arb8_ctrl_if.sv - request/grant bundle between eight clients and the round-robin arbiter
interface rr_arb8_ctrl_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic [7:0] hold_cnt;

    // master: the client side raising requests; slave: the arbiter
    modport master (
        output req,
        output done,
        input  grant,
        input  sel,
        input  valid,
        input  hold_cnt
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output sel,
        output valid,
        output hold_cnt
    );
endinterface

// File: rtl/rr_arb8_ctrl.sv
// rtl/rr_arb8_ctrl.sv - eight-requester round-robin arbiter driving a registered DMux8Way/Mux8Way select
module rr_arb8_ctrl #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    rr_arb8_ctrl_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit         HOLD_EN   = (HOLD_MAX != 0);
    localparam logic [7:0] HOLD_LAST = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

    state_t     state, state_nx;
    logic [2:0] ptr, ptr_nx;
    logic [2:0] sel_r, sel_nx;
    logic [7:0] grant_r, grant_nx;
    logic [7:0] hold_r, hold_nx;

    logic       release_c;
    logic [2:0] scan_base;
    logic       win_found;
    logic [2:0] win_idx;

    // Scan base, base+1, ... base+7 (mod 8); the lowest offset with a request wins.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = base + 3'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        sel_nx    = sel_r;
        grant_nx  = grant_r;
        hold_nx   = hold_r;

        release_c = (state == GRANT) &&
                    (bus.done || !bus.req[sel_r] || (HOLD_EN && (hold_r == HOLD_LAST)));

        // On release the pointer moves past the current grantee, making it lowest priority
        // for the re-arbitration that happens on this very edge.
        scan_base = release_c ? (sel_r + 3'd1) : ptr;
        {win_found, win_idx} = rr_pick(bus.req, scan_base);

        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nx = GRANT;
                    grant_nx = 8'b1 << win_idx;
                    sel_nx   = win_idx;
                    hold_nx  = 8'd0;
                end
            end
            GRANT: begin
                if (release_c) begin
                    ptr_nx = sel_r + 3'd1;
                    if (win_found) begin
                        grant_nx = 8'b1 << win_idx;
                        sel_nx   = win_idx;
                        hold_nx  = 8'd0;
                    end else begin
                        state_nx = IDLE;
                        grant_nx = 8'd0;
                        hold_nx  = 8'd0;
                    end
                end else if (hold_r != 8'hFF) begin
                    hold_nx = hold_r + 8'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = 8'd0;
                hold_nx  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= 3'd0;
            sel_r   <= 3'd0;
            grant_r <= 8'd0;
            hold_r  <= 8'd0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            sel_r   <= sel_nx;
            grant_r <= grant_nx;
            hold_r  <= hold_nx;
        end
    end

    // All outputs come straight from flops so the steering select never glitches.
    assign bus.grant    = grant_r;
    assign bus.sel      = sel_r;
    assign bus.valid    = (state == GRANT);
    assign bus.hold_cnt = hold_r;

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// tb/tb_rr_arb8_ctrl.sv - directed plus randomized check of rr_arb8_ctrl against a behavioural model
module tb_rr_arb8_ctrl;

    logic clk;
    logic reset0;
    logic reset1;

    rr_arb8_ctrl_if bus0 ();
    rr_arb8_ctrl_if bus1 ();

    rr_arb8_ctrl #(.HOLD_MAX(4)) dut0 (
        .clk   (clk),
        .reset (reset0),
        .bus   (bus0)
    );

    rr_arb8_ctrl #(.HOLD_MAX(0)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model of dut0: owner is the granted client or -1 when idle.
    localparam int M_HOLD_MAX = 4;
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    int m_sel   = 0;

    function automatic int pick(input logic [7:0] r, input int base);
        for (int k = 0; k < 8; k++) begin
            if (r[(base + k) % 8]) return (base + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_step();
        int  w;
        bit  rel;
        if (reset0) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0;
        end else if (m_owner < 0) begin
            w = pick(bus0.req, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_hold = 0;
            end
        end else begin
            rel = bus0.done || !bus0.req[m_owner] ||
                  (M_HOLD_MAX != 0 && m_hold == M_HOLD_MAX - 1);
            if (rel) begin
                m_ptr = (m_owner + 1) % 8;
                w = pick(bus0.req, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_sel = w; m_hold = 0;
                end else begin
                    m_owner = -1; m_hold = 0;
                end
            end else if (m_hold < 255) begin
                m_hold++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("model_grant", 32'(bus0.grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("model_sel",   32'(bus0.sel),   32'(m_sel));
        chk("model_valid", 32'(bus0.valid), (m_owner >= 0) ? 32'd1 : 32'd0);
        chk("model_hold",  32'(bus0.hold_cnt), 32'(m_hold));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic chk0(input string tag, input logic [7:0] g, input logic [2:0] s, input logic v);
        chk({tag, "_grant"}, 32'(bus0.grant), 32'(g));
        chk({tag, "_sel"},   32'(bus0.sel),   32'(s));
        chk({tag, "_valid"}, 32'(bus0.valid), 32'(v));
    endtask

    initial begin
        reset0 = 1'b1; reset1 = 1'b1;
        bus0.req = 8'hFF; bus0.done = 1'b0;
        bus1.req = 8'h01; bus1.done = 1'b0;

        // reset held two cycles with all requesting
        tick(); chk0("rst1", 8'h00, 3'd0, 1'b0); chk("rst1_hold", 32'(bus0.hold_cnt), 32'd0);
        tick(); chk0("rst2", 8'h00, 3'd0, 1'b0);
        reset0 = 1'b0;
        tick(); chk0("first", 8'h01, 3'd0, 1'b1);

        // rotation with done one cycle after each grant, then on to sel=6
        for (int i = 1; i <= 14; i++) begin
            bus0.done = 1'b0;
            tick(); chk0("rot_hold", 8'(1 << ((i - 1) % 8)), 3'((i - 1) % 8), 1'b1);
            bus0.done = 1'b1;
            tick(); chk0("rot_next", 8'(1 << (i % 8)), 3'(i % 8), 1'b1);
        end

        // sparse wrap-around from sel=6
        bus0.req = 8'b0100_0101; bus0.done = 1'b1;
        tick(); chk0("sparse0", 8'h01, 3'd0, 1'b1);
        tick(); chk0("sparse2", 8'h04, 3'd2, 1'b1);
        tick(); chk0("sparse6", 8'h40, 3'd6, 1'b1);
        bus0.done = 1'b0;

        // timeout with HOLD_MAX=4
        reset0 = 1'b1; bus0.req = 8'h03;
        tick(); reset0 = 1'b0;
        tick(); chk0("to_a", 8'h01, 3'd0, 1'b1); chk("to_a_hold", 32'(bus0.hold_cnt), 32'd0);
        for (int k = 1; k < 4; k++) begin
            tick(); chk0("to_a", 8'h01, 3'd0, 1'b1); chk("to_a_hold", 32'(bus0.hold_cnt), 32'(k));
        end
        for (int k = 0; k < 4; k++) begin
            tick(); chk0("to_b", 8'h02, 3'd1, 1'b1); chk("to_b_hold", 32'(bus0.hold_cnt), 32'(k));
        end
        tick(); chk0("to_c", 8'h01, 3'd0, 1'b1); chk("to_c_hold", 32'(bus0.hold_cnt), 32'd0);

        // no hold limit: 300 cycles, hold_cnt saturates
        reset1 = 1'b0;
        tick(); chk("nolim_grant", 32'(bus1.grant), 32'h01); chk("nolim_hold", 32'(bus1.hold_cnt), 32'd0);
        for (int k = 1; k < 300; k++) begin
            tick();
            chk("nolim_grant", 32'(bus1.grant), 32'h01);
            chk("nolim_hold", 32'(bus1.hold_cnt), 32'((k > 255) ? 255 : k));
        end

        // withdrawal then idle then re-request
        reset0 = 1'b1; bus0.req = 8'h08;
        tick(); reset0 = 1'b0;
        tick(); chk0("wd_grant", 8'h08, 3'd3, 1'b1);
        bus0.req = 8'h00;
        tick(); chk0("wd_idle", 8'h00, 3'd3, 1'b0);
        tick(); chk0("wd_idle2", 8'h00, 3'd3, 1'b0);
        bus0.req = 8'h08;
        tick(); chk0("wd_regrant", 8'h08, 3'd3, 1'b1);

        // reset mid-grant restores ptr=0
        reset0 = 1'b1; bus0.req = 8'h20;
        tick(); reset0 = 1'b0;
        tick(); chk0("mr_grant", 8'h20, 3'd5, 1'b1);
        reset0 = 1'b1;
        tick(); chk0("mr_reset", 8'h00, 3'd0, 1'b0);
        reset0 = 1'b0; bus0.req = 8'h21;
        tick(); chk0("mr_after", 8'h01, 3'd0, 1'b1);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                bus0.req = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            end
            bus0.done = ($urandom_range(0, 3) == 0);
            reset0    = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
